// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath types: register-address and word widths plus
// the hardwired-zero register index.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback bus of the register file: two read ports and one write port.
interface register_file_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = REG_ADDR_W
) ();

  // Reads have no handshake: read_dataN follows read_addrN combinationally.
  // write_enable is a plain strobe sampled on the rising clock edge; there is
  // no ready, so every strobed write with a non-zero address is accepted.
  logic [ADDR_WIDTH-1:0] read_addr1;
  logic [ADDR_WIDTH-1:0] read_addr2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;

  modport master (
    output read_addr1,
    output read_addr2,
    input  read_data1,
    input  read_data2,
    output write_addr,
    output write_data,
    output write_enable
  );

  modport slave (
    input  read_addr1,
    input  read_addr2,
    output read_data1,
    output read_data2,
    input  write_addr,
    input  write_data,
    input  write_enable
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, optional write-through bypass and
// forcing of register 0. Instantiated once per port so both behave identically.
module regfile_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                    read_addr,
  input  logic                                     wr_fire,
  input  logic [ADDR_WIDTH-1:0]                    write_addr,
  input  logic [DATA_WIDTH-1:0]                    write_data,
  output logic [DATA_WIDTH-1:0]                    read_data
);

  logic bypass_hit;

  // wr_fire already excludes register 0 and reset, so a hit is always legal.
  assign bypass_hit = wr_fire && (read_addr == write_addr);

  always_comb begin
    read_data = regs[read_addr];
    if ((BYPASS != 0) && bypass_hit) begin
      read_data = write_data;
    end
    if (read_addr == '0) begin
      read_data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS32 register file: two combinational reads, one clocked
// write, register 0 hardwired to zero, asynchronous active-low clear.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int BYPASS     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  bus
);

  localparam int                    NUM_REGS  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;
  logic                                wr_fire;

  // Gating with rst_n keeps the bypass path quiet while the array is cleared.
  assign wr_fire = rst_n && bus.write_enable && (bus.write_addr != ZERO_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[bus.write_addr] = bus.write_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_read_port1 (
    .regs       (regs_q),
    .read_addr  (bus.read_addr1),
    .wr_fire    (wr_fire),
    .write_addr (bus.write_addr),
    .write_data (bus.write_data),
    .read_data  (bus.read_data1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_read_port2 (
    .regs       (regs_q),
    .read_addr  (bus.read_addr2),
    .wr_fire    (wr_fire),
    .write_addr (bus.write_addr),
    .write_data (bus.write_data),
    .read_data  (bus.read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a write-through and a stored-read instance share
// one stimulus stream and are checked against an array model every cycle.
module tb_register_file;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;

  int checks   = 0;
  int failures = 0;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_b ();
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_n ();

  assign if_b.write_enable = we;
  assign if_b.write_addr   = wa;
  assign if_b.write_data   = wd;
  assign if_b.read_addr1   = ra1;
  assign if_b.read_addr2   = ra2;
  assign if_n.write_enable = we;
  assign if_n.write_addr   = wa;
  assign if_n.write_data   = wd;
  assign if_n.read_addr1   = ra1;
  assign if_n.read_addr2   = ra2;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_n)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] mem [32] = '{default: '0};

  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (rst_n && we && wa != 5'd0) mem[wa] = wd;
  end

  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
    if (!rst_n || addr == 5'd0) return 32'h0;
    if (byp && we && wa == addr) return wd;
    return mem[addr];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("byp_rd1", if_b.read_data1, exp_read(ra1, 1'b1));
    check("byp_rd2", if_b.read_data2, exp_read(ra2, 1'b1));
    check("nob_rd1", if_n.read_data1, exp_read(ra1, 1'b0));
    check("nob_rd2", if_n.read_data2, exp_read(ra2, 1'b0));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    step();
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1 check("reset_rd1", if_b.read_data1, 32'h0);
    rst_n = 1'b1;

    // Asynchronous clear of a written register
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1 check("r5_written", if_n.read_data1, 32'hDEADBEEF);
    check("model_r5", mem[5], 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 check("r5_async_clr_b", if_b.read_data1, 32'h0);
    check("r5_async_clr_n", if_n.read_data1, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("r5_after_release", if_b.read_data1, 32'h0);

    // Fill every address with 1
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h1, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd0);
    #1 check("fill_r2", if_b.read_data1, 32'h1);
    check("fill_r0", if_b.read_data2, 32'h0);
    check("model_r0", mem[0], 32'h0);

    // Overwrite, neighbour untouched
    drive(1'b1, 5'h10, 32'h100, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'h10, 5'h11);
    #1 check("ovw_r16", if_n.read_data1, 32'h100);
    check("ovw_r17", if_n.read_data2, 32'h1);

    // Write-enable gating
    drive(1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
    step();
    check("gate_r3", if_b.read_data1, 32'h1);

    // Bypass vs stored read
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    #1 check("byp_r7_p1", if_b.read_data1, 32'h12345678);
    check("byp_r7_p2", if_b.read_data2, 32'h12345678);
    check("nob_r7_p1", if_n.read_data1, 32'h1);
    check("nob_r7_p2", if_n.read_data2, 32'h1);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #1 check("nob_r7_after", if_n.read_data2, 32'h12345678);

    // No bypass through register 0
    drive(1'b1, 5'd0, 32'hCAFEF00D, 5'd0, 5'd0);
    #1 check("byp_r0", if_b.read_data1, 32'h0);
    step();

    // Reset held across a write edge wins
    drive(1'b1, 5'd4, 32'h55, 5'd4, 5'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
    #1 check("rst_wins_r4", if_n.read_data1, 32'h0);

    // Dual-port independence and swap
    drive(1'b1, 5'd9, 32'hAAAA5555, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd10, 32'h5555AAAA, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    #1 check("dual_p1", if_b.read_data1, 32'hAAAA5555);
    check("dual_p2", if_b.read_data2, 32'h5555AAAA);
    drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
    #1 check("swap_p1", if_n.read_data1, 32'h5555AAAA);
    check("swap_p2", if_n.read_data2, 32'hAAAA5555);
    step();

    // Random traffic with occasional mid-cycle resets
    repeat (1500) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 49) == 0) begin
        #($urandom_range(1, 2));
        rst_n = 1'b0;
      end
      step();
      if (!rst_n) rst_n = 1'b1;
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit general-purpose register file for the MIPS32 datapath, sitting between decode (two source-operand reads) and writeback (one destination write).
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Asynchronous active-low reset clears all registers.

Parameters:
- DATA_WIDTH, 32, width of each register and of data ports.
- ADDR_WIDTH, 5, width of register addresses; register count is 2**ADDR_WIDTH (32).
- BYPASS, 1, when 1 a read of the register being written this cycle returns write_data (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_addr1  input  ADDR_WIDTH  address for read port 1 (rs).
- read_addr2  input  ADDR_WIDTH  address for read port 2 (rt).
- read_data1  output  DATA_WIDTH  contents of register read_addr1.
- read_data2  output  DATA_WIDTH  contents of register read_addr2.
- write_addr  input  ADDR_WIDTH  destination register address.
- write_data  input  DATA_WIDTH  data to write.
- write_enable  input  1  active-high write strobe, sampled at the rising edge of clk.

Behaviour:
- Reset:
  - When rst_n is low, all registers are cleared to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, both read_data outputs are 0.
  - Writes are blocked while rst_n is low.
  - Release is synchronous-safe: the first write is accepted on the first rising edge with rst_n high.
- Write:
  - On the rising edge of clk with write_enable=1 and write_addr!=0, the register at write_addr takes write_data.
  - Write latency is one edge; the value is visible at the stored-read path after that edge.
  - If write_enable=0, no register changes.
  - If write_addr=0, the write is silently discarded.
- Read:
  - Purely combinational from read_addr and register contents, with zero cycle latency.
  - Reads of address 0 always return 0.
  - Both ports are independent and may address the same register.
- Bypass (BYPASS=1):
  - If write_enable=1, write_addr!=0 and read_addrN==write_addr, read_dataN = write_data in that same cycle.
  - Never bypass for address 0.
  - With BYPASS=0, read_dataN shows the old value until after the edge.
- Width rules:
  - Addresses are exactly ADDR_WIDTH bits.
  - Upper bits of any wider driver are truncated by the connection and are not the block's concern.
  - Data is stored unmodified, with no sign or zero extension.
- Simultaneous events:
  - Reset asserted at the same time as a write edge: reset wins and the register stays 0.
  - A write and two reads of the same register in one cycle is legal; the bypass rule above applies.
- No X propagation: every register has a defined reset value. Outputs are fully defined for every address.

Decomposition:
- Shared package, mips_pkg, holds:
  - REG_ADDR_W=5 and WORD_W=32;
  - typedef reg_addr_t (logic [4:0]) and typedef word_t (logic [31:0]);
  - localparam REG_ZERO=5'd0.
- One natural sub-module, regfile_read_port, instantiated twice. It contains a single read mux with the zero-register forcing and bypass compare, so both ports are guaranteed identical.
- Storage array and write logic stay in register_file.

Test Plan:
- Reset: assert rst_n=0 mid-operation after writing 0xDEADBEEF to r5 -> read_data1 for r5 is 0 immediately, without waiting for a clock edge. It stays 0 after release until a new write.
- Fill all: write_enable=1, write 0x00000001 to addresses 0..31 over 32 edges, then write_enable=0:
  - read_addr1=2 -> read_data1=0x00000001;
  - read_addr2=0 -> read_data2=0x00000000, because r0 is hardwired.
- Overwrite: write 0x00000100 to address 0x10, then read_addr1=0x10 -> 0x00000100. Simultaneously read_addr2=0x11 -> 0x00000001, so neighbours are unchanged.
- Write-enable gating: write_enable=0, write_addr=3, write_data=0xFFFFFFFF, clock an edge -> read of r3 still returns the prior value (0x00000001).
- Bypass: write_enable=1, write_addr=7, write_data=0x12345678, read_addr1=read_addr2=7 before the edge:
  - BYPASS=1 -> both ports read 0x12345678 combinationally;
  - BYPASS=0 -> both ports show the old value until after the edge.
- Dual-port independence: r9=0xAAAA5555 and r10=0x5555AAAA, read_addr1=9 and read_addr2=10 -> each port returns its own value. Swapping the addresses swaps the outputs in the same cycle.
